// File: rtl/sparc_exu_alu_wbpipe_if.sv
// ALU writeback pipe bus: E-stage capture, bypass, IRF write port.
// Groups every non-clock signal between ecl/lsu and the wbpipe.
interface sparc_exu_alu_wbpipe_if #(
    parameter int DW     = 64,
    parameter int TIDW   = 2,
    parameter int RDW    = 5,
    parameter int QDEPTH = 2
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [DW-1:0]   alu_byp_rd_data_e;
    logic            ecl_wb_vld_e;
    logic [TIDW-1:0] ecl_wb_tid_e;
    logic [RDW-1:0]  ecl_wb_rd_e;
    logic            ecl_wb_kill_m;
    logic            lsu_exu_wen_g;
    logic [TIDW-1:0] ecl_byp_tid_d;
    logic [RDW-1:0]  ecl_byp_rs_d;

    logic            exu_ecl_wb_stall;
    logic            exu_ecl_wbq_hit;
    logic [DW-1:0]   alu_byp_rd_data_m;
    logic            alu_byp_vld_m;
    logic [DW-1:0]   alu_byp_rd_data_w;
    logic            wb_irf_wen_w;
    logic [TIDW-1:0] wb_irf_tid_w;
    logic [RDW-1:0]  wb_irf_rd_w;
    logic [DW-1:0]   wb_irf_data_w;
    logic [DW/8-1:0] wb_irf_par_w;
    logic [CW-1:0]   wb_q_cnt;

    modport slave (
        input  alu_byp_rd_data_e,
        input  ecl_wb_vld_e,
        input  ecl_wb_tid_e,
        input  ecl_wb_rd_e,
        input  ecl_wb_kill_m,
        input  lsu_exu_wen_g,
        input  ecl_byp_tid_d,
        input  ecl_byp_rs_d,
        output exu_ecl_wb_stall,
        output exu_ecl_wbq_hit,
        output alu_byp_rd_data_m,
        output alu_byp_vld_m,
        output alu_byp_rd_data_w,
        output wb_irf_wen_w,
        output wb_irf_tid_w,
        output wb_irf_rd_w,
        output wb_irf_data_w,
        output wb_irf_par_w,
        output wb_q_cnt
    );

    modport master (
        output alu_byp_rd_data_e,
        output ecl_wb_vld_e,
        output ecl_wb_tid_e,
        output ecl_wb_rd_e,
        output ecl_wb_kill_m,
        output lsu_exu_wen_g,
        output ecl_byp_tid_d,
        output ecl_byp_rs_d,
        input  exu_ecl_wb_stall,
        input  exu_ecl_wbq_hit,
        input  alu_byp_rd_data_m,
        input  alu_byp_vld_m,
        input  alu_byp_rd_data_w,
        input  wb_irf_wen_w,
        input  wb_irf_tid_w,
        input  wb_irf_rd_w,
        input  wb_irf_data_w,
        input  wb_irf_par_w,
        input  wb_q_cnt
    );
endinterface

// File: rtl/sparc_exu_alu_wbpipe.sv
// EXU ALU E->M->W pipe with deferred IRF writeback queue.
// Optional byte parity on the write port: SPARC_EXU_WB_PARITY_EN.
module sparc_exu_alu_wbpipe #(
    parameter int DW     = 64,
    parameter int TIDW   = 2,
    parameter int RDW    = 5,
    parameter int QDEPTH = 2
) (
    input logic                   rclk,
    input logic                   reset,
    sparc_exu_alu_wbpipe_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int PW = DW / 8;

    logic            r_m_vld;
    logic [DW-1:0]   r_m_data;
    logic [TIDW-1:0] r_m_tid;
    logic [RDW-1:0]  r_m_rd;

    logic            r_w_vld;
    logic [DW-1:0]   r_w_data;
    logic [TIDW-1:0] r_w_tid;
    logic [RDW-1:0]  r_w_rd;

    logic [DW-1:0]   r_q_data [QDEPTH];
    logic [TIDW-1:0] r_q_tid  [QDEPTH];
    logic [RDW-1:0]  r_q_rd   [QDEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_hold;
    logic            w_push;
    logic            w_pop;
    logic            w_wen;
    logic            w_sel_q;
    logic            w_hit;
    logic [AW-1:0]   w_idx;

    assign w_full  = (r_cnt == CW'(QDEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_hold  = r_w_vld & bus.lsu_exu_wen_g & w_full;

`ifdef SPARC_EXU_WB_PARITY_EN
    logic [PW-1:0] r_q_par [QDEPTH];
    logic [PW-1:0] w_w_par;
    logic [PW-1:0] w_par;

    // Even parity per byte of the W-stage result.
    always_comb begin
        w_w_par = '0;
        for (int i = 0; i < PW; i++) begin
            w_w_par[i] = ^r_w_data[8*i +: 8];
        end
    end

    // Parity follows the same source as the write data.
    always_comb begin
        w_par = '0;
        if (w_wen) begin
            w_par = w_sel_q ? r_q_par[r_rptr] : w_w_par;
        end
    end

    // Parity stored alongside each queued entry.
    always_ff @(posedge rclk) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_par[i] <= '0;
            end
        end else if (w_push) begin
            r_q_par[r_wptr] <= w_w_par;
        end
    end

    assign bus.wb_irf_par_w = w_par;
`else
    assign bus.wb_irf_par_w = '0;
`endif

    // W-stage port arbitration: load return, then queue head, then W.
    always_comb begin
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_wen   = 1'b0;
        w_sel_q = 1'b0;
        if (bus.lsu_exu_wen_g) begin
            w_push = r_w_vld & ~w_full;
        end else if (!w_empty) begin
            w_wen   = 1'b1;
            w_sel_q = 1'b1;
            w_pop   = 1'b1;
            w_push  = r_w_vld;
        end else if (r_w_vld) begin
            w_wen = 1'b1;
        end
    end

    // IRF write port, zeroed whenever no write is issued.
    always_comb begin
        bus.wb_irf_wen_w  = w_wen;
        bus.wb_irf_tid_w  = '0;
        bus.wb_irf_rd_w   = '0;
        bus.wb_irf_data_w = '0;
        if (w_wen && w_sel_q) begin
            bus.wb_irf_tid_w  = r_q_tid[r_rptr];
            bus.wb_irf_rd_w   = r_q_rd[r_rptr];
            bus.wb_irf_data_w = r_q_data[r_rptr];
        end else if (w_wen) begin
            bus.wb_irf_tid_w  = r_w_tid;
            bus.wb_irf_rd_w   = r_w_rd;
            bus.wb_irf_data_w = r_w_data;
        end
    end

    // RAW check of a source against every live queue entry.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            w_idx = r_rptr + AW'(k);
            if ((CW'(k) < r_cnt) &&
                (r_q_tid[w_idx] == bus.ecl_byp_tid_d) &&
                (r_q_rd[w_idx] == bus.ecl_byp_rs_d)) begin
                w_hit = 1'b1;
            end
        end
    end

    // M and W stage registers; a hold freezes both but still kills M.
    always_ff @(posedge rclk) begin
        if (reset) begin
            r_m_vld  <= 1'b0;
            r_m_data <= '0;
            r_m_tid  <= '0;
            r_m_rd   <= '0;
            r_w_vld  <= 1'b0;
            r_w_data <= '0;
            r_w_tid  <= '0;
            r_w_rd   <= '0;
        end else if (w_hold) begin
            r_m_vld <= r_m_vld & ~bus.ecl_wb_kill_m;
        end else begin
            r_w_vld  <= r_m_vld & ~bus.ecl_wb_kill_m;
            r_w_data <= r_m_data;
            r_w_tid  <= r_m_tid;
            r_w_rd   <= r_m_rd;
            r_m_vld  <= bus.ecl_wb_vld_e;
            r_m_data <= bus.alu_byp_rd_data_e;
            r_m_tid  <= bus.ecl_wb_tid_e;
            r_m_rd   <= bus.ecl_wb_rd_e;
        end
    end

    // Circular deferred-writeback queue; full push+pop keeps count.
    always_ff @(posedge rclk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_tid[i]  <= '0;
                r_q_rd[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_q_data[r_wptr] <= r_w_data;
                r_q_tid[r_wptr]  <= r_w_tid;
                r_q_rd[r_wptr]   <= r_w_rd;
                r_wptr           <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.exu_ecl_wb_stall  = w_hold;
    assign bus.exu_ecl_wbq_hit   = w_hit;
    assign bus.alu_byp_rd_data_m = r_m_data;
    assign bus.alu_byp_vld_m     = r_m_vld;
    assign bus.alu_byp_rd_data_w = r_w_data;
    assign bus.wb_q_cnt          = r_cnt;
endmodule

// File: tb/tb_sparc_exu_alu_wbpipe.sv
// Self-checking bench for sparc_exu_alu_wbpipe.
// IRF writes are checked in order against a scoreboard queue.
module tb_sparc_exu_alu_wbpipe;
    localparam int DW     = 64;
    localparam int TIDW   = 2;
    localparam int RDW    = 5;
    localparam int QDEPTH = 2;

`ifdef SPARC_EXU_WB_PARITY_EN
    localparam logic [7:0] PAR_301 = 8'h01;
    localparam logic [7:0] PAR_701 = 8'h81;
`else
    localparam logic [7:0] PAR_301 = 8'h00;
    localparam logic [7:0] PAR_701 = 8'h00;
`endif

    typedef struct packed {
        logic [TIDW-1:0] tid;
        logic [RDW-1:0]  rd;
        logic [DW-1:0]   data;
    } wr_t;

    logic rclk = 1'b0;
    logic reset;
    wr_t  sb [$];
    wr_t  exp_wr;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_wr   = 0;

    always #5 rclk = ~rclk;

    sparc_exu_alu_wbpipe_if #(
        .DW(DW), .TIDW(TIDW), .RDW(RDW), .QDEPTH(QDEPTH)
    ) bus ();

    sparc_exu_alu_wbpipe #(
        .DW(DW), .TIDW(TIDW), .RDW(RDW), .QDEPTH(QDEPTH)
    ) u_dut (
        .rclk (rclk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [7:0] exp_par(input logic [DW-1:0] d);
        logic [7:0] p;
        p = 8'h00;
`ifdef SPARC_EXU_WB_PARITY_EN
        for (int i = 0; i < 8; i++) p[i] = ^d[8*i +: 8];
`endif
        return p;
    endfunction

    // Scoreboard: every IRF write must match the oldest expected entry.
    always @(negedge rclk) begin
        #3;
        if (bus.wb_irf_wen_w === 1'b1) begin
            n_wr++;
            n_tot++;
            if (sb.size() == 0) begin
                $display("FAIL irf_unexpected got tid=%0d rd=%0d data=%h want none",
                         bus.wb_irf_tid_w, bus.wb_irf_rd_w, bus.wb_irf_data_w);
            end else begin
                exp_wr = sb.pop_front();
                if ({bus.wb_irf_tid_w, bus.wb_irf_rd_w, bus.wb_irf_data_w,
                     bus.wb_irf_par_w} !==
                    {exp_wr.tid, exp_wr.rd, exp_wr.data, exp_par(exp_wr.data)}) begin
                    $display("FAIL irf_write got tid=%0d rd=%0d data=%h par=%h want tid=%0d rd=%0d data=%h par=%h",
                             bus.wb_irf_tid_w, bus.wb_irf_rd_w, bus.wb_irf_data_w,
                             bus.wb_irf_par_w, exp_wr.tid, exp_wr.rd, exp_wr.data,
                             exp_par(exp_wr.data));
                end else begin
                    n_pass++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.ecl_wb_vld_e      = 1'b0;
        bus.alu_byp_rd_data_e = '0;
        bus.ecl_wb_tid_e      = '0;
        bus.ecl_wb_rd_e       = '0;
    endtask

    task automatic drive(input wr_t op);
        bus.ecl_wb_vld_e      = 1'b1;
        bus.alu_byp_rd_data_e = op.data;
        bus.ecl_wb_tid_e      = op.tid;
        bus.ecl_wb_rd_e       = op.rd;
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        reset                 = 1'b1;
        bus.ecl_wb_vld_e      = 1'b1;
        bus.alu_byp_rd_data_e = 64'hDEAD_BEEF;
        bus.ecl_wb_tid_e      = 2'd3;
        bus.ecl_wb_rd_e       = 5'd9;
        bus.ecl_wb_kill_m     = 1'b0;
        bus.lsu_exu_wen_g     = 1'b0;
        bus.ecl_byp_tid_d     = 2'd3;
        bus.ecl_byp_rs_d      = 5'd9;
        for (int c = 0; c < 3; c++) begin
            @(negedge rclk);
            if (c == 2) begin
                reset = 1'b0;
                idle();
            end
            #1;
            outs = '0;
            outs = {bus.exu_ecl_wb_stall, bus.exu_ecl_wbq_hit,
                    bus.alu_byp_rd_data_m, bus.alu_byp_vld_m,
                    bus.alu_byp_rd_data_w, bus.wb_irf_wen_w,
                    bus.wb_irf_tid_w, bus.wb_irf_rd_w,
                    bus.wb_irf_data_w, bus.wb_irf_par_w, bus.wb_q_cnt};
            n_tot++;
            if (outs !== '0) begin
                $display("FAIL reset_outputs cycle=%0d got %h want 0", c, outs);
            end else begin
                n_pass++;
            end
        end
    endtask

    task automatic test_single();
        wr_t op;
        int  w0;
        op = '{tid: 2'd1, rd: 5'd5, data: 64'h1234};
        w0 = n_wr;
        @(negedge rclk);
        drive(op);
        #1;
        n_tot++;
        if (bus.exu_ecl_wb_stall !== 1'b0) begin
            $display("FAIL single_stall got %b want 0", bus.exu_ecl_wb_stall);
        end else begin
            n_pass++;
        end
        sb.push_back(op);
        @(negedge rclk);
        idle();
        #1;
        n_tot++;
        if ({bus.alu_byp_vld_m, bus.alu_byp_rd_data_m} !== {1'b1, op.data}) begin
            $display("FAIL single_m got vld=%b data=%h want vld=1 data=%h",
                     bus.alu_byp_vld_m, bus.alu_byp_rd_data_m, op.data);
        end else begin
            n_pass++;
        end
        @(negedge rclk);
        #1;
        n_tot++;
        if ({bus.wb_irf_wen_w, bus.alu_byp_rd_data_w} !== {1'b1, op.data}) begin
            $display("FAIL single_w got wen=%b data=%h want wen=1 data=%h",
                     bus.wb_irf_wen_w, bus.alu_byp_rd_data_w, op.data);
        end else begin
            n_pass++;
        end
        @(negedge rclk);
        #1;
        n_tot++;
        if (bus.wb_irf_wen_w !== 1'b0) begin
            $display("FAIL single_after got wen=%b want 0", bus.wb_irf_wen_w);
        end else begin
            n_pass++;
        end
        repeat (2) @(negedge rclk);
        n_tot++;
        if ((n_wr - w0) != 1 || sb.size() != 0) begin
            $display("FAIL single_count got writes=%0d left=%0d want 1 0",
                     n_wr - w0, sb.size());
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_defer();
        wr_t op;
        op = '{tid: 2'd2, rd: 5'd3, data: 64'hAAAA_0003};
        @(negedge rclk);
        drive(op);
        sb.push_back(op);
        @(negedge rclk);
        idle();
        @(negedge rclk);
        bus.lsu_exu_wen_g = 1'b1;
        #1;
        n_tot++;
        if ({bus.wb_irf_wen_w, bus.exu_ecl_wb_stall} !== 2'b00) begin
            $display("FAIL defer_lsu got wen=%b stall=%b want 0 0",
                     bus.wb_irf_wen_w, bus.exu_ecl_wb_stall);
        end else begin
            n_pass++;
        end
        @(negedge rclk);
        bus.lsu_exu_wen_g = 1'b0;
        bus.ecl_byp_tid_d = 2'd2;
        bus.ecl_byp_rs_d  = 5'd4;
        #1;
        n_tot++;
        if (bus.exu_ecl_wbq_hit !== 1'b0) begin
            $display("FAIL defer_miss got hit=%b want 0", bus.exu_ecl_wbq_hit);
        end else begin
            n_pass++;
        end
        bus.ecl_byp_rs_d = 5'd3;
        #1;
        n_tot++;
        if ({bus.wb_q_cnt, bus.exu_ecl_wbq_hit, bus.wb_irf_wen_w} !== {2'd1, 2'b11}) begin
            $display("FAIL defer_drain got cnt=%0d hit=%b wen=%b want 1 1 1",
                     bus.wb_q_cnt, bus.exu_ecl_wbq_hit, bus.wb_irf_wen_w);
        end else begin
            n_pass++;
        end
        @(negedge rclk);
        #1;
        n_tot++;
        if ({bus.wb_q_cnt, bus.exu_ecl_wbq_hit, bus.wb_irf_wen_w} !== {2'd0, 2'b00}) begin
            $display("FAIL defer_empty got cnt=%0d hit=%b wen=%b want 0 0 0",
                     bus.wb_q_cnt, bus.exu_ecl_wbq_hit, bus.wb_irf_wen_w);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        wr_t ops [5];
        int  i;
        int  w0;
        logic st;
        for (int k = 0; k < 5; k++) begin
            ops[k] = '{tid: 2'(k), rd: 5'(10 + k), data: 64'hB000 + 64'(k)};
        end
        i  = 0;
        w0 = n_wr;
        bus.ecl_byp_tid_d = 2'd1;
        bus.ecl_byp_rs_d  = 5'd11;
        for (int c = 0; c < 14; c++) begin
            @(negedge rclk);
            bus.lsu_exu_wen_g = (c >= 2 && c <= 5);
            if (i < 5) drive(ops[i]);
            else idle();
            #1;
            st = bus.exu_ecl_wb_stall;
            if (c == 3) begin
                n_tot++;
                if (st !== 1'b0) begin
                    $display("FAIL b2b_nostall got %b want 0", st);
                end else begin
                    n_pass++;
                end
            end
            if (c == 4 || c == 5) begin
                n_tot++;
                if ({st, bus.wb_q_cnt} !== {1'b1, 2'd2}) begin
                    $display("FAIL b2b_stall c=%0d got stall=%b cnt=%0d want 1 2",
                             c, st, bus.wb_q_cnt);
                end else begin
                    n_pass++;
                end
            end
            if (c == 5) begin
                n_tot++;
                if ({bus.alu_byp_rd_data_m, bus.alu_byp_rd_data_w,
                     bus.exu_ecl_wbq_hit} !== {ops[3].data, ops[2].data, 1'b1}) begin
                    $display("FAIL b2b_hold got m=%h w=%h hit=%b want %h %h 1",
                             bus.alu_byp_rd_data_m, bus.alu_byp_rd_data_w,
                             bus.exu_ecl_wbq_hit, ops[3].data, ops[2].data);
                end else begin
                    n_pass++;
                end
            end
            if (i < 5 && st === 1'b0) begin
                sb.push_back(ops[i]);
                i++;
            end
        end
        n_tot++;
        if ((n_wr - w0) != 5 || sb.size() != 0 || bus.wb_q_cnt !== 2'd0) begin
            $display("FAIL b2b_count got writes=%0d left=%0d cnt=%0d want 5 0 0",
                     n_wr - w0, sb.size(), bus.wb_q_cnt);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_kill();
        wr_t ope;
        wr_t opf;
        int  w0;
        ope = '{tid: 2'd3, rd: 5'd7, data: 64'hE0};
        opf = '{tid: 2'd3, rd: 5'd8, data: 64'hF0};
        w0  = n_wr;
        @(negedge rclk);
        drive(ope);
        @(negedge rclk);
        drive(opf);
        bus.ecl_wb_kill_m = 1'b1;
        sb.push_back(opf);
        @(negedge rclk);
        idle();
        bus.ecl_wb_kill_m = 1'b0;
        #1;
        n_tot++;
        if ({bus.wb_irf_wen_w, bus.alu_byp_vld_m} !== 2'b01) begin
            $display("FAIL kill_w got wen=%b vld_m=%b want 0 1",
                     bus.wb_irf_wen_w, bus.alu_byp_vld_m);
        end else begin
            n_pass++;
        end
        @(negedge rclk);
        #1;
        n_tot++;
        if ({bus.wb_irf_wen_w, bus.wb_irf_rd_w} !== {1'b1, 5'd8}) begin
            $display("FAIL kill_next got wen=%b rd=%0d want 1 8",
                     bus.wb_irf_wen_w, bus.wb_irf_rd_w);
        end else begin
            n_pass++;
        end
        repeat (2) @(negedge rclk);
        n_tot++;
        if ((n_wr - w0) != 1 || sb.size() != 0) begin
            $display("FAIL kill_count got writes=%0d left=%0d want 1 0",
                     n_wr - w0, sb.size());
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_parity();
        wr_t op;
        op = '{tid: 2'd0, rd: 5'd1, data: 64'h0000_0000_0000_0301};
        @(negedge rclk);
        drive(op);
        sb.push_back(op);
        @(negedge rclk);
        idle();
        @(negedge rclk);
        #1;
        n_tot++;
        if ({bus.wb_irf_wen_w, bus.wb_irf_par_w} !== {1'b1, PAR_301}) begin
            $display("FAIL parity_direct got wen=%b par=%h want 1 %h",
                     bus.wb_irf_wen_w, bus.wb_irf_par_w, PAR_301);
        end else begin
            n_pass++;
        end
        op = '{tid: 2'd1, rd: 5'd2, data: 64'h0700_0000_0000_0001};
        @(negedge rclk);
        drive(op);
        sb.push_back(op);
        @(negedge rclk);
        idle();
        @(negedge rclk);
        bus.lsu_exu_wen_g = 1'b1;
        @(negedge rclk);
        bus.lsu_exu_wen_g = 1'b0;
        #1;
        n_tot++;
        if ({bus.wb_irf_wen_w, bus.wb_irf_par_w} !== {1'b1, PAR_701}) begin
            $display("FAIL parity_queued got wen=%b par=%h want 1 %h",
                     bus.wb_irf_wen_w, bus.wb_irf_par_w, PAR_701);
        end else begin
            n_pass++;
        end
        repeat (2) @(negedge rclk);
        n_tot++;
        if (sb.size() != 0) begin
            $display("FAIL parity_left got %0d want 0", sb.size());
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_defer();
        test_back_to_back();
        test_kill();
        test_parity();
        repeat (3) @(negedge rclk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
